// File: rtl/level_sensor_pkg.sv
// Shared types and constants for the tank level-sensor conditioner.
package level_sensor_pkg;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    NORMAL  = 2'd1,
    SUSPECT = 2'd2,
    FAULT   = 2'd3
  } cond_state_t;

  // Both switches reported wet: the pump FSM reads this as "both pumps off".
  localparam logic [1:0] SAFE_LEVELS    = 2'b11;
  // Upper wet while lower dry cannot happen physically.
  localparam logic [1:0] INVALID_LEVELS = 2'b10;

  localparam int SENSOR_I = 0;
  localparam int SENSOR_S = 1;

endpackage

// File: rtl/level_sensor_conditioner_debouncer.sv
// One float switch: two-flop synchroniser followed by a debounce counter.
// In init_mode the debounced bit simply follows the synchroniser and the
// counter measures how long the bit has been stable (saturating).
module sensor_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic init_mode,
  output logic deb,
  output logic stable
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Bring the asynchronous switch into the clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
    end
  end

  // Debounce counter and debounced bit; stability tracking while priming.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (init_mode) begin
      deb <= sync;
      if (sync != deb) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
    end else if (sync == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= sync;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stable = (sync == deb) && (cnt == CNT_LAST);

endmodule

// File: rtl/level_sensor_conditioner.sv
// Conditions the lower (I) and upper (S) float switches for the pump FSM:
// synchronise, debounce, and latch a fault on a persistent "upper wet,
// lower dry" pattern. Outputs the safe pattern while priming or faulted.
//
// state   | meaning
// INIT    | priming: waiting for both switches to be stable
// NORMAL  | debounced levels passed through
// SUSPECT | invalid pattern seen, timing how long it persists
// FAULT   | invalid pattern persisted; held until fault_clear
module level_sensor_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FAULT_CYCLES    = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] raw_sensors,
  input  logic       fault_clear,
  output logic [1:0] level_sensors,
  output logic       sensor_valid,
  output logic       sensor_fault
);

  import level_sensor_pkg::*;

  localparam int unsigned FCW = $clog2(FAULT_CYCLES);
  // The transition edge is the one on which the counter reaches FAULT_CYCLES-1.
  localparam logic [FCW-1:0] FCNT_PRE_LAST = FCW'(FAULT_CYCLES - 2);

  cond_state_t    state, state_next;
  logic [FCW-1:0] fcnt, fcnt_next;
  logic [1:0]     deb;
  logic [1:0]     stable;
  logic           init_mode;

  assign init_mode = (state_next == INIT);

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_i (
    .clock     (clock),
    .reset     (reset),
    .raw       (raw_sensors[SENSOR_I]),
    .init_mode (init_mode),
    .deb       (deb[SENSOR_I]),
    .stable    (stable[SENSOR_I])
  );

  sensor_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_s (
    .clock     (clock),
    .reset     (reset),
    .raw       (raw_sensors[SENSOR_S]),
    .init_mode (init_mode),
    .deb       (deb[SENSOR_S]),
    .stable    (stable[SENSOR_S])
  );

  // State register and fault-persistence counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      fcnt  <= '0;
    end else begin
      state <= state_next;
      fcnt  <= fcnt_next;
    end
  end

  // Next-state logic for priming, suspicion timing and fault latching.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    case (state)
      INIT: begin
        if (&stable) state_next = NORMAL;
      end
      NORMAL: begin
        if (deb == INVALID_LEVELS) begin
          state_next = SUSPECT;
          fcnt_next  = '0;
        end
      end
      SUSPECT: begin
        fcnt_next = fcnt + 1'b1;
        if (deb != INVALID_LEVELS) begin
          state_next = NORMAL;
        end else if (fcnt == FCNT_PRE_LAST) begin
          state_next = FAULT;
        end
      end
      FAULT: begin
        if (fault_clear && (deb != INVALID_LEVELS)) state_next = NORMAL;
      end
      default: state_next = INIT;
    endcase
  end

  // Registered outputs; the safe pattern is shown unless levels are trusted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_sensors <= SAFE_LEVELS;
      sensor_valid  <= 1'b0;
      sensor_fault  <= 1'b0;
    end else begin
      sensor_valid  <= (state == NORMAL) || (state == SUSPECT);
      sensor_fault  <= (state == FAULT);
      level_sensors <= ((state == NORMAL) || (state == SUSPECT)) ? deb : SAFE_LEVELS;
    end
  end

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Directed bench for level_sensor_conditioner with DEBOUNCE_CYCLES=4 and
// FAULT_CYCLES=8. Edge counts in comments are relative to the edge after
// which the input was changed.
module tb_level_sensor_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] raw_sensors;
  logic       fault_clear;
  logic [1:0] level_sensors;
  logic       sensor_valid;
  logic       sensor_fault;

  int tests  = 0;
  int failed = 0;

  level_sensor_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .FAULT_CYCLES    (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .raw_sensors   (raw_sensors),
    .fault_clear   (fault_clear),
    .level_sensors (level_sensors),
    .sensor_valid  (sensor_valid),
    .sensor_fault  (sensor_fault)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] lvl,
                               input logic vld, input logic flt);
    check({tag, "_level"}, level_sensors, lvl);
    check({tag, "_valid"}, {1'b0, sensor_valid}, {1'b0, vld});
    check({tag, "_fault"}, {1'b0, sensor_fault}, {1'b0, flt});
  endtask

  initial begin
    reset       = 1'b1;
    raw_sensors = 2'b01;
    fault_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset", 2'b11, 1'b0, 1'b0);
    reset = 1'b0;

    // Startup: outputs stay safe through edge 7, valid at edge 8.
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("startup_level", level_sensors, 2'b11);
      check("startup_valid", {1'b0, sensor_valid}, 2'b00);
    end
    tick();
    check_outputs("primed", 2'b01, 1'b1, 1'b0);

    // Move to 00: raw sampled at +1, level updates at +7.
    raw_sensors = 2'b00;
    repeat (7) tick();
    check_outputs("to_00", 2'b00, 1'b1, 1'b0);

    // Three-cycle glitch on the lower switch is rejected.
    raw_sensors = 2'b01;
    repeat (3) tick();
    raw_sensors = 2'b00;
    repeat (8) tick();
    check("glitch_level", level_sensors, 2'b00);

    // Held change: still 00 at k+5, 01 at k+6 (k = +1).
    raw_sensors = 2'b01;
    repeat (6) tick();
    check("hold_k5", level_sensors, 2'b00);
    tick();
    check("hold_k6", level_sensors, 2'b01);

    // Invalid pattern for 7 debounced cycles: visible, but no fault.
    raw_sensors = 2'b10;
    repeat (7) tick();
    check_outputs("transient_suspect", 2'b10, 1'b1, 1'b0);
    raw_sensors = 2'b01;
    repeat (7) tick();
    check("transient_back", level_sensors, 2'b01);
    repeat (6) tick();
    check_outputs("transient_nofault", 2'b01, 1'b1, 1'b0);

    // Persistent invalid pattern: deb=10 at +6, fault shown at +15.
    raw_sensors = 2'b10;
    repeat (7) tick();
    check_outputs("suspect", 2'b10, 1'b1, 1'b0);
    repeat (7) tick();
    check_outputs("pre_fault", 2'b10, 1'b1, 1'b0);
    tick();
    check_outputs("fault", 2'b11, 1'b0, 1'b1);

    // Clear request with the invalid pattern still present is ignored.
    fault_clear = 1'b1;
    repeat (2) tick();
    fault_clear = 1'b0;
    tick();
    check_outputs("clear_ignored", 2'b11, 1'b0, 1'b1);

    // Once 11 is debounced, a clear returns to NORMAL one edge later.
    raw_sensors = 2'b11;
    repeat (8) tick();
    check_outputs("fault_held", 2'b11, 1'b0, 1'b1);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    tick();
    check_outputs("cleared", 2'b11, 1'b1, 1'b0);

    // Asynchronous reset while in SUSPECT.
    raw_sensors = 2'b10;
    repeat (8) tick();
    check_outputs("suspect2", 2'b10, 1'b1, 1'b0);
    #3 reset = 1'b1;
    #1;
    check_outputs("reset_suspect", 2'b11, 1'b0, 1'b0);
    tick();
    reset = 1'b0;

    // Prime with the invalid pattern present, reach FAULT, then reset.
    repeat (20) tick();
    check_outputs("fault_after_prime", 2'b11, 1'b0, 1'b1);
    #3 reset = 1'b1;
    #1;
    check_outputs("reset_fault", 2'b11, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
